// File: rtl/axis_frame_serializer.sv
// Frame-to-AXI-Stream serializer: two-slot frame buffer, one {channel, sample} beat per channel, tlast per packet.
// Optional macro AXIS_FRAME_SERIALIZER_SEQ_EN places a per-frame sequence count in the unused upper tdata bits.
module axis_frame_serializer #(
  parameter int CHANNEL_COUNT      = 16,
  parameter int DATA_WIDTH         = 16,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FRAMES_PER_PACKET  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] s_frame_data,
  input  logic                              s_frame_valid,
  output logic                              s_frame_ready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tlast,
  output logic                              idle
);

  localparam int CW  = $clog2(CHANNEL_COUNT);
  localparam int FW  = CHANNEL_COUNT * DATA_WIDTH;
  localparam int PW  = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1;
  localparam int SW  = C_AXIS_TDATA_WIDTH - CW - DATA_WIDTH;
  localparam int SWF = (SW > 0) ? SW : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   slot [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic [CW-1:0]   ch_idx, ch_idx_nxt;
  logic [PW-1:0]   pkt_cnt;
  logic            push, pop, beat_hs, last_ch, pkt_last;
  logic [FW-1:0]   head;
  logic [DATA_WIDTH-1:0] sample;
  logic [C_AXIS_TDATA_WIDTH-1:0] beat;

  // Ready is decoded from the registered count only, so a pop never opens the buffer in the same cycle.
  assign s_frame_ready = ~count[1];
  assign push     = s_frame_valid & s_frame_ready;
  assign beat_hs  = m00_axis_tvalid & m00_axis_tready;
  assign last_ch  = (ch_idx == CW'(CHANNEL_COUNT - 1));
  assign pop      = beat_hs & last_ch;
  assign pkt_last = (pkt_cnt == PW'(FRAMES_PER_PACKET - 1));

  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= s_frame_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ch_idx  <= '0;
      count   <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ch_idx <= ch_idx_nxt;
      count  <= count + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pkt_cnt <= pkt_last ? '0 : pkt_cnt + PW'(1);
      end
    end
  end

  // A frame being pushed counts as available, giving a one-cycle accept-to-tvalid latency
  // and no bubble when a new frame arrives on the same cycle the head pops.
  always_comb begin
    state_nxt  = state;
    ch_idx_nxt = ch_idx;
    case (state)
      IDLE: begin
        if (count != 2'd0 || push) begin
          state_nxt  = SEND;
          ch_idx_nxt = '0;
        end
      end
      SEND: begin
        if (beat_hs) begin
          if (!last_ch) begin
            ch_idx_nxt = ch_idx + CW'(1);
          end else begin
            ch_idx_nxt = '0;
            if (!(count > 2'd1 || push)) state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        ch_idx_nxt = '0;
      end
    endcase
  end

`ifdef AXIS_FRAME_SERIALIZER_SEQ_EN
  logic [SWF-1:0] seq_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      seq_cnt <= '0;
    else if (pop) seq_cnt <= seq_cnt + SWF'(1);
  end
`endif

  assign head   = slot[rd_ptr];
  assign sample = head[ch_idx*DATA_WIDTH +: DATA_WIDTH];

  // Outputs are gated by state so they clear the instant rst is asserted.
  always_comb begin
    beat = '0;
    if (m00_axis_tvalid) begin
      beat[DATA_WIDTH-1:0]          = sample;
      beat[CW+DATA_WIDTH-1:DATA_WIDTH] = ch_idx;
`ifdef AXIS_FRAME_SERIALIZER_SEQ_EN
      beat = beat | (C_AXIS_TDATA_WIDTH'(seq_cnt) << (CW + DATA_WIDTH));
`endif
    end
  end

  assign m00_axis_tvalid = (state == SEND);
  assign m00_axis_tdata  = beat;
  assign m00_axis_tlast  = m00_axis_tvalid & last_ch & pkt_last;
  assign m00_axis_tstrb  = {(C_AXIS_TDATA_WIDTH/8){m00_axis_tvalid}};
  assign idle            = (state == IDLE) && (count == 2'd0);

endmodule
